// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_ctrl
// Brief    : Periodic ECC memory scrubber. Reads one word per interval, runs it
//            through an external Hsiao decoder, writes back corrected words
//            and counts corrected / uncorrectable errors. Shares the memory
//            port with a host that is granted whenever the scrubber is idle.
//            Optional macro ECC_SCRUB_LOG_EN adds a sticky fatal-address log
//            (ports fatal_addr / fatal_vld).
// Revision : 1.0 - initial release
// ============================================================================
module ecc_scrub_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scrub_en,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [71:0]       mem_rdata,
    output logic [71:0]       mem_wdata,
    output logic              dec_enable,
    output logic [71:0]       dec_code,
    input  logic [63:0]       dec_data,
    input  logic              dec_err_corr,
    input  logic              dec_err_detec,
    input  logic              dec_err_fatal,
    output logic [63:0]       enc_data,
    input  logic [71:0]       enc_code,
    output logic              busy,
    output logic              scrub_wrap,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  fatal_cnt
`ifdef ECC_SCRUB_LOG_EN
   ,output logic [ADDR_W-1:0] fatal_addr,
    output logic              fatal_vld
`endif
);

    localparam int                 c_INT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [c_INT_W-1:0] c_RELOAD   = c_INT_W'(INTERVAL - 1);
    localparam logic [4:0]         c_WAIT_MAX = 5'd16;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_DEC1 = 3'd2;
    localparam logic [2:0] c_DEC2 = 3'd3;
    localparam logic [2:0] c_CHK  = 3'd4;
    localparam logic [2:0] c_WB   = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_INT_W-1:0] r_int_cnt;
    logic               r_pend;
    logic [4:0]         r_wait;
    logic [ADDR_W-1:0]  r_addr;
    logic [71:0]        r_code;
    logic [CNT_W-1:0]   r_corr;
    logic [CNT_W-1:0]   r_fatal;
    logic               r_wrap;

    logic w_tick;
    logic w_scrub_wins;
    logic w_host_win;
    logic w_launch;
    logic w_corr_ev;
    logic w_fatal_ev;
    logic w_advance;

    assign w_tick       = scrub_en & (r_int_cnt == '0);
    // A scrub that has waited long enough beats the host, so scrubbing cannot starve.
    assign w_scrub_wins = r_pend & (r_wait >= c_WAIT_MAX);
    assign w_host_win   = host_req & ~w_scrub_wins;
    assign w_launch     = (r_state == c_IDLE) & r_pend & ~w_host_win;
    // A correctable report from the decoder also counts as a detection.
    assign w_corr_ev    = (r_state == c_CHK) & (dec_err_detec | dec_err_corr) & ~dec_err_fatal;
    assign w_fatal_ev   = (r_state == c_CHK) & dec_err_fatal;
    // Address moves on only when the word is finished (not on CHK -> WB).
    assign w_advance    = ((r_state == c_CHK) & ~w_corr_ev) | (r_state == c_WB);

    assign mem_addr   = r_addr;
    assign scrub_wrap = r_wrap;
    assign corr_cnt   = r_corr;
    assign fatal_cnt  = r_fatal;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and per-state memory / decoder strobes
    always_comb begin
        w_next     = r_state;
        host_gnt   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        dec_enable = 1'b0;
        busy       = 1'b1;
        enc_data   = '0;
        mem_wdata  = '0;
        dec_code   = r_code;
        case (r_state)
            c_IDLE: begin
                busy     = 1'b0;
                host_gnt = w_host_win;
                if (w_launch) w_next = c_RD;
            end
            c_RD: begin
                mem_rd = 1'b1;
                w_next = c_DEC1;
            end
            c_DEC1: begin
                // Read data is only on the bus this cycle; present it directly.
                dec_enable = 1'b1;
                dec_code   = mem_rdata;
                w_next     = c_DEC2;
            end
            c_DEC2: begin
                dec_enable = 1'b1;
                w_next     = c_CHK;
            end
            c_CHK: begin
                w_next = w_corr_ev ? c_WB : c_IDLE;
            end
            c_WB: begin
                enc_data  = dec_data;
                mem_wdata = enc_code;
                mem_wr    = 1'b1;
                w_next    = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
        // Reset aborts immediately: no strobe may escape in the reset cycle.
        if (reset) begin
            host_gnt   = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            dec_enable = 1'b0;
        end
    end

    // Interval timer and pending-scrub flag with its starvation wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_cnt <= c_RELOAD;
            r_pend    <= 1'b0;
            r_wait    <= '0;
        end else begin
            if (scrub_en) begin
                if (r_int_cnt == '0) r_int_cnt <= c_RELOAD;
                else                 r_int_cnt <= r_int_cnt - c_INT_W'(1);
            end
            r_pend <= w_tick | (r_pend & ~w_launch);
            if (w_launch || !r_pend)     r_wait <= '0;
            else if (r_wait != c_WAIT_MAX) r_wait <= r_wait + 5'd1;
        end
    end

    // Scrub address, wrap pulse and captured codeword
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
            r_code <= '0;
        end else begin
            r_wrap <= w_advance & (&r_addr);
            if (w_advance)          r_addr <= r_addr + ADDR_W'(1);
            if (r_state == c_DEC1)  r_code <= mem_rdata;
        end
    end

    // Saturating error counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_corr  <= '0;
            r_fatal <= '0;
        end else begin
            if (w_corr_ev && !(&r_corr))   r_corr  <= r_corr + CNT_W'(1);
            if (w_fatal_ev && !(&r_fatal)) r_fatal <= r_fatal + CNT_W'(1);
        end
    end

`ifdef ECC_SCRUB_LOG_EN
    logic [ADDR_W-1:0] r_fatal_addr;
    logic              r_fatal_vld;

    assign fatal_addr = r_fatal_addr;
    assign fatal_vld  = r_fatal_vld;

    // Last uncorrectable address, with a sticky valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fatal_addr <= '0;
            r_fatal_vld  <= 1'b0;
        end else if (w_fatal_ev) begin
            r_fatal_addr <= r_addr;
            r_fatal_vld  <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrub_ctrl
// Brief    : Self-checking bench for ecc_scrub_ctrl with a behavioural memory,
//            parity-byte encoder and golden-compare decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_scrub_ctrl;

    localparam int AW = 3;
    localparam int IV = 8;
    localparam int CW = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          reset, scrub_en, host_req, host_gnt, mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [71:0]   mem_rdata, mem_wdata, dec_code, enc_code, golden, diff;
    logic          dec_enable, dec_err_corr, dec_err_detec, dec_err_fatal;
    logic [63:0]   dec_data, enc_data;
    logic          busy, scrub_wrap;
    logic [CW-1:0] corr_cnt, fatal_cnt;
`ifdef ECC_SCRUB_LOG_EN
    logic [AW-1:0] fatal_addr;
    logic          fatal_vld;
`endif

    int errors = 0, checks = 0;
    int cyc_n = 0, last_rd = 0, wr_cnt = 0, wrap_cnt = 0, gnt_cnt = 0;
    int exp_addr = 0, exp_corr = 0, exp_fatal = 0, exp_wrap = 0;
    logic [71:0] mem   [NW];
    logic [71:0] clean [NW];

    ecc_scrub_ctrl #(.ADDR_W(AW), .INTERVAL(IV), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .scrub_en(scrub_en),
        .host_req(host_req), .host_gnt(host_gnt),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .dec_enable(dec_enable), .dec_code(dec_code), .dec_data(dec_data),
        .dec_err_corr(dec_err_corr), .dec_err_detec(dec_err_detec),
        .dec_err_fatal(dec_err_fatal),
        .enc_data(enc_data), .enc_code(enc_code),
        .busy(busy), .scrub_wrap(scrub_wrap),
        .corr_cnt(corr_cnt), .fatal_cnt(fatal_cnt)
`ifdef ECC_SCRUB_LOG_EN
       ,.fatal_addr(fatal_addr), .fatal_vld(fatal_vld)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) c[i] = ^d[i*8 +: 8];
        return {c, d};
    endfunction

    // Encoder and decoder models: the decoder knows the clean word being scrubbed.
    assign enc_code      = encode(enc_data);
    assign diff          = dec_code ^ golden;
    assign dec_err_detec = (diff != 72'd0);
    assign dec_err_corr  = ($countones(diff) == 1);
    assign dec_err_fatal = ($countones(diff) > 1);
    assign dec_data      = golden[63:0];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (mem_wr === 1'b1) begin
            wr_cnt++;
            mem[mem_addr] = mem_wdata;
        end
        if (mem_rd === 1'b1) begin
            mem_rdata = mem[mem_addr];
            golden    = clean[mem_addr];
        end
        if (scrub_wrap === 1'b1) wrap_cnt++;
        if (host_gnt === 1'b1)   gnt_cnt++;
        check("exclusive_strobes", 72'($countones({mem_rd, mem_wr, dec_enable, host_gnt}) <= 1), 72'(1));
        check("gnt_while_busy", 72'(host_gnt & busy), 72'(0));
    endtask

    task automatic flip(input int a, input int b);
        mem[a][b] = ~mem[a][b];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_mem_rd", 72'(mem_rd), 72'(0));
        check("rst_mem_wr", 72'(mem_wr), 72'(0));
        check("rst_dec_en", 72'(dec_enable), 72'(0));
        check("rst_host_gnt", 72'(host_gnt), 72'(0));
        check("rst_mem_addr", 72'(mem_addr), 72'(0));
        check("rst_mem_wdata", mem_wdata, 72'(0));
        check("rst_enc_data", 72'(enc_data), 72'(0));
        check("rst_dec_code", dec_code, 72'(0));
        check("rst_wrap", 72'(scrub_wrap), 72'(0));
        check("rst_corr_cnt", 72'(corr_cnt), 72'(0));
        check("rst_fatal_cnt", 72'(fatal_cnt), 72'(0));
`ifdef ECC_SCRUB_LOG_EN
        check("rst_fatal_vld", 72'(fatal_vld), 72'(0));
        check("rst_fatal_addr", 72'(fatal_addr), 72'(0));
`endif
        reset    = 1'b0;
        last_rd  = cyc_n;
        exp_addr = 0;
        exp_corr = 0;
        exp_fatal = 0;
        gnt_cnt  = 0;
    endtask

    // One complete scrub of the next word, checked against the model.
    task automatic scrub_one(input int exp_gap);
        int to;
        int a;
        int nerr;
        int w0;
        to = 0;
        while (mem_rd !== 1'b1 && to < 4*IV + 40) begin
            cyc();
            to++;
        end
        check("rd_timeout", 72'(mem_rd), 72'(1));
        if (mem_rd !== 1'b1) return;
        check("rd_gap", 72'(cyc_n - last_rd), 72'(exp_gap));
        last_rd = cyc_n;
        a = exp_addr;
        check("rd_addr", 72'(mem_addr), 72'(a));
        nerr = $countones(mem[a] ^ clean[a]);
        w0 = wr_cnt;
        cyc();
        check("dec1_en", 72'(dec_enable), 72'(1));
        cyc();
        check("dec2_en", 72'(dec_enable), 72'(1));
        cyc();
        check("chk_dec_en", 72'(dec_enable), 72'(0));
        check("chk_busy", 72'(busy), 72'(1));
        cyc();
        if (nerr == 1) begin
            check("wb_mem_wr", 72'(mem_wr), 72'(1));
            check("wb_addr", 72'(mem_addr), 72'(a));
            check("wb_data", mem_wdata, clean[a]);
            cyc();
            exp_corr = (exp_corr + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : exp_corr + 1;
        end else if (nerr >= 2) begin
            exp_fatal = (exp_fatal + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : exp_fatal + 1;
        end
        if (a == NW - 1) exp_wrap++;
        exp_addr = (a + 1) % NW;
        check("end_busy", 72'(busy), 72'(0));
        check("end_wr_count", 72'(wr_cnt - w0), 72'(nerr == 1 ? 1 : 0));
        check("end_corr_cnt", 72'(corr_cnt), 72'(exp_corr));
        check("end_fatal_cnt", 72'(fatal_cnt), 72'(exp_fatal));
        check("end_wrap_count", 72'(wrap_cnt), 72'(exp_wrap));
        check("end_next_addr", 72'(mem_addr), 72'(exp_addr));
`ifdef ECC_SCRUB_LOG_EN
        if (nerr >= 2) begin
            check("log_fatal_vld", 72'(fatal_vld), 72'(1));
            check("log_fatal_addr", 72'(fatal_addr), 72'(a));
        end
`endif
    endtask

    initial begin
        int r;
        int b1;
        int w0;
        int to;
        reset     = 1'b1;
        scrub_en  = 1'b1;
        host_req  = 1'b0;
        mem_rdata = '0;
        golden    = '0;
        for (int i = 0; i < NW; i++) begin
            clean[i] = encode({$urandom, $urandom});
            mem[i]   = clean[i];
        end

        // Clean memory: periodic reads, no write-backs, one wrap.
        do_reset();
        for (int k = 0; k < 10; k++) scrub_one(k == 0 ? IV + 1 : IV);
        check("clean_no_writes", 72'(wr_cnt), 72'(0));

        // Single error at word 5 bit 17, double error at word 3, one random single.
        flip(5, 17);
        b1 = $urandom_range(71, 0);
        flip(3, b1);
        flip(3, (b1 + 1 + $urandom_range(70, 0)) % 72);
        r = $urandom_range(7, 0);
        if (r == 3 || r == 5) r = 6;
        flip(r, $urandom_range(71, 0));
        for (int k = 0; k < 8; k++) scrub_one(IV);
        check("word5_repaired", mem[5], clean[5]);

        // Many corrections drive the counter into saturation.
        for (int i = 0; i < NW; i++) mem[i] = clean[i];
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NW; i++) flip(i, $urandom_range(71, 0));
            for (int k = 0; k < 8; k++) scrub_one(IV);
        end
        check("corr_saturated", 72'(corr_cnt), 72'((1 << CW) - 1));

        // Host holding the port: scrub wins after waiting 16 cycles.
        host_req = 1'b1;
        do_reset();
        scrub_one(IV + 17);
        check("host_gnt_total", 72'(gnt_cnt), 72'(IV + 16));
        check("host_gnt_after", 72'(host_gnt), 72'(1));

        // Reset during DEC2 of a correctable word aborts without write-back.
        host_req = 1'b0;
        flip(exp_addr, $urandom_range(71, 0));
        to = 0;
        while (mem_rd !== 1'b1 && to < 4*IV + 40) begin
            cyc();
            to++;
        end
        check("abort_rd_timeout", 72'(mem_rd), 72'(1));
        cyc();
        cyc();
        check("abort_in_dec2", 72'(dec_enable), 72'(1));
        reset = 1'b1;
        w0 = wr_cnt;
        cyc();
        check("abort_idle", 72'(busy), 72'(0));
        check("abort_no_wr", 72'(mem_wr), 72'(0));
        check("abort_addr", 72'(mem_addr), 72'(0));
        reset = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check("abort_wr_count", 72'(wr_cnt - w0), 72'(0));
        check("abort_corr_cnt", 72'(corr_cnt), 72'(0));
        check("abort_fatal_cnt", 72'(fatal_cnt), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, memory word-address width.
REQ-002 Parameter: INTERVAL, 1024, clock cycles between scrub launches (>=8).
REQ-003 Parameter: CNT_W, 16, width of the error counters.
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: scrub_en  in  1  enables periodic scrubbing.
REQ-007 Port: host_req / host_gnt  in / out  1 / 1  host request for the memory port, and its one-cycle grant.
REQ-008 Port: mem_rd / mem_wr  out  1 / 1  memory read/write strobes; read data arrives one cycle after mem_rd.
REQ-009 Port: mem_addr  out  ADDR_W  scrub address.
REQ-010 Port: mem_rdata / mem_wdata  in / out  72 / 72  stored / write-back codeword.
REQ-011 Port: dec_enable / dec_code  out  1 / 72  enable and codeword to the 64-bit Hsiao decoder.
REQ-012 Port: dec_data, dec_err_corr, dec_err_detec, dec_err_fatal  in  64,1,1,1  decoder results.
REQ-013 Port: enc_data / enc_code  out / in  64 / 72  to/from the combinational Hsiao encoder.
REQ-014 Port: busy, scrub_wrap  out  1, 1  scrub in progress; one-cycle pulse on address wrap.
REQ-015 Port: corr_cnt, fatal_cnt  out  CNT_W each  corrected / uncorrectable error counts.

Function
REQ-016 Interval counter shall decrement every cycle while scrub_en=1, set scrub_pend at 0 and reload INTERVAL-1; it shall hold while scrub_en=0.
REQ-017 FSM states shall be IDLE, RD, DEC1, DEC2, CHK, WB.
REQ-018 In IDLE, host_req=1 shall assert host_gnt that cycle and defer scrub, unless scrub_pend has been waiting >=16 cycles, in which case scrub wins.
REQ-019 IDLE->RD when scrub_pend=1 and not granting host; scrub_pend clears on entry to RD.
REQ-020 RD: mem_rd=1, mem_addr=scrub address; next state DEC1.
REQ-021 DEC1: capture mem_rdata into a 72-bit register driving dec_code; dec_enable=1 in DEC1 and DEC2 only.
REQ-022 CHK: sample decoder outputs exactly 2 cycles after DEC1 entry.
REQ-023 CHK: if dec_err_detec=1 and dec_err_fatal=0, increment corr_cnt and go to WB; if dec_err_fatal=1, increment fatal_cnt, no write-back, return to IDLE; otherwise return to IDLE.
REQ-024 WB: enc_data=dec_data, mem_wr=1, mem_wdata=enc_code, same mem_addr; next state IDLE.
REQ-025 Scrub address shall increment on leaving CHK/WB; from 2^ADDR_W-1 it wraps to 0 and pulses scrub_wrap.
REQ-026 Counters shall saturate at all-ones.
REQ-027 busy=1 in every state except IDLE; host_gnt=0 whenever busy=1 (scrub is not pre-emptible).
REQ-028 scrub_en deasserted mid-scrub shall let the current operation complete.
REQ-029 mem_rd, mem_wr, dec_enable, host_gnt shall never be asserted simultaneously with each other.

Reset
REQ-030 reset=1 shall force IDLE next cycle, abort any operation without issuing mem_wr, and clear scrub address, interval counter (to INTERVAL-1), scrub_pend, wait counter, corr_cnt, fatal_cnt.
REQ-031 All outputs shall be 0 after reset.

Configuration
REQ-032 With ECC_SCRUB_LOG_EN defined, ports fatal_addr (out, ADDR_W) and fatal_vld (out, 1) shall exist; on each fatal error fatal_addr captures the scrub address and fatal_vld sets sticky until reset.
REQ-033 Without ECC_SCRUB_LOG_EN, those ports and registers shall be absent; all other behaviour is identical.

Verification
REQ-034 INTERVAL=8, scrub_en=1, clean memory -> mem_rd every 8 cycles, no mem_wr, counters stay 0, DEC1 to CHK = 2 cycles.
REQ-035 Word 5 with data bit 17 flipped -> corr_cnt=1, mem_wr at address 5 with corrected re-encoded codeword.
REQ-036 Word 3 with two bits flipped -> fatal_cnt=1, no mem_wr, fatal_addr=3 and fatal_vld=1 when ECC_SCRUB_LOG_EN is defined.
REQ-037 ADDR_W=2, run 4 scrubs -> address 3->0, scrub_wrap pulses once.
REQ-038 host_req held high continuously -> scrub starts 16 cycles after scrub_pend; reset asserted in DEC2 -> IDLE next cycle, no mem_wr, counters 0.
